// File: rtl/spi_rx_buffer_if.sv
// Bundle of the SPI-side capture inputs and the downstream byte stream/status.
// The master modport is the buffer itself; the slave modport is whoever feeds and drains it.
interface spi_rx_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          spi_done;
  logic [7:0]    spi_data;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          clr_overflow;

  modport master (
    input  spi_done, spi_data, m_ready, clr_overflow,
    output m_valid, m_data, count, full, empty, overflow
  );

  modport slave (
    output spi_done, spi_data, m_ready, clr_overflow,
    input  m_valid, m_data, count, full, empty, overflow
  );
endinterface

// File: rtl/spi_rx_buffer.sv
// Synchronises the SPI slave's done level, captures one byte per done pulse into an
// FWFT FIFO and presents it on a valid/ready stream with occupancy and overflow status.
module spi_rx_buffer #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_rx_buffer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   ds;
  logic                   ds_prev;
  logic                   armed;
  logic                   push;
  logic                   pop;
  logic                   wr_en;
  logic [7:0]             mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          cnt;
  logic                   ovf;
  logic                   full_i;
  logic                   empty_i;

  assign ds      = sync_q[SYNC_STAGES-1];
  assign full_i  = (cnt == CW'(DEPTH));
  assign empty_i = (cnt == '0);
  assign push    = ds & ~ds_prev & armed;
  assign pop     = ~empty_i & bus.m_ready;
  assign wr_en   = push & (~full_i | pop);

  // primed_q tracks which sync stages hold real post-reset samples, so the reset
  // zeros flushing out of the chain cannot arm capture of a done that never dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      primed_q <= '0;
      ds_prev  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.spi_done};
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      ds_prev  <= ds;
      armed    <= armed | (~ds & primed_q[SYNC_STAGES-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // A drop beats a simultaneous clear so no lost byte goes unreported.
      if (push & full_i & ~pop)  ovf <= 1'b1;
      else if (bus.clr_overflow) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.spi_data;
  end

  assign bus.m_valid  = ~empty_i;
  assign bus.m_data   = mem[rd_ptr];
  assign bus.count    = cnt;
  assign bus.full     = full_i;
  assign bus.empty    = empty_i;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_spi_rx_buffer.sv
// Scoreboard bench for spi_rx_buffer: directed corner cases plus a randomised stream.
module tb_spi_rx_buffer;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  spi_rx_buffer_if #(.DEPTH(DEPTH)) bus ();

  spi_rx_buffer #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  logic [7:0] q[$];
  bit   inflight = 0;
  bit   rand_en = 0;
  bit   manual_ready = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sole driver of m_ready, updated away from both the edge and the sampling point.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      bus.m_ready = rand_en ? 1'($urandom_range(0, 1)) : manual_ready;
    end
  end

  // Monitor: compares popped bytes, occupancy and stall stability against the model.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (!inflight) begin
          check("count", 32'(bus.count), q.size());
          check("empty", 32'(bus.empty), 32'(q.size() == 0));
          check("full", 32'(bus.full), 32'(q.size() == DEPTH));
          check("m_valid", 32'(bus.m_valid), 32'(q.size() != 0));
        end
        if (prev_stall && bus.m_valid) check("stall_data", 32'(bus.m_data), 32'(prev_data));
        if (bus.m_valid && bus.m_ready) begin
          if (q.size() == 0) begin
            check("unexpected_pop", 32'(bus.m_data), 32'hFFFF_FFFF);
          end else begin
            exp = q.pop_front();
            check("order", 32'(bus.m_data), 32'(exp));
          end
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // mode: 0 plain, 1 pop coincides with the write edge, 2 clr_overflow at the write edge.
  task automatic send(input logic [7:0] b, input int hold, input int mode, input bit lat_chk);
    bit drop;
    inflight = 1;
    drop = (q.size() >= DEPTH) && (mode != 1);
    if (!drop) q.push_back(b);
    @(posedge clk); #1;
    bus.spi_data = b;
    bus.spi_done = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (lat_chk) check("lat_before", 32'(bus.m_valid), 32'd0);
    if (mode == 1) manual_ready = 1'b1;
    if (mode == 2) bus.clr_overflow = 1'b1;
    @(posedge clk); #1;
    if (lat_chk) begin
      check("lat_valid", 32'(bus.m_valid), 32'd1);
      check("lat_data", 32'(bus.m_data), 32'(b));
    end
    manual_ready = 1'b0;
    bus.clr_overflow = 1'b0;
    inflight = 0;
    repeat (hold - 3) @(posedge clk);
    #1;
    bus.spi_done = 1'b0;
    bus.spi_data = 8'($urandom);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    manual_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    #1;
    manual_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) check("drain_timeout", q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.spi_done = 1'b0;
    bus.spi_data = 8'h00;
    bus.clr_overflow = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk); #1;

    // Single long pulse gives one byte; a one-cycle ready takes it.
    send(8'hA5, 4, 0, 1);
    check("one_write", 32'(bus.count), 32'd1);
    manual_ready = 1'b1;
    @(posedge clk); #1;
    manual_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("one_pop_count", 32'(bus.count), 32'd0);
    check("one_pop_empty", 32'(bus.empty), 32'd1);

    // Fill, overflow drop, drain.
    for (int i = 1; i <= 8; i++) send(8'(i), 4, 0, 0);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd8);
    check("fill_ovf", 32'(bus.overflow), 32'd0);
    send(8'h09, 4, 0, 0);
    check("drop_ovf", 32'(bus.overflow), 32'd1);
    check("drop_count", 32'(bus.count), 32'd8);
    drain();

    bus.clr_overflow = 1'b1;
    @(posedge clk); #1;
    bus.clr_overflow = 1'b0;
    check("clr_ovf", 32'(bus.overflow), 32'd0);

    // Push coinciding with pop on a full FIFO.
    for (int i = 1; i <= 8; i++) send(8'(i), 4, 0, 0);
    send(8'h09, 4, 1, 0);
    check("pushpop_ovf", 32'(bus.overflow), 32'd0);
    check("pushpop_count", 32'(bus.count), 32'd8);

    // Drop and clear in the same cycle: set wins.
    send(8'h0A, 4, 2, 0);
    check("set_wins_ovf", 32'(bus.overflow), 32'd1);
    check("set_wins_count", 32'(bus.count), 32'd8);
    drain();
    bus.clr_overflow = 1'b1;
    @(posedge clk); #1;
    bus.clr_overflow = 1'b0;
    check("clr_ovf2", 32'(bus.overflow), 32'd0);

    // done held high across reset release is not captured.
    bus.spi_data = 8'h77;
    bus.spi_done = 1'b1;
    do_reset();
    repeat (10) @(posedge clk); #1;
    check("held_done_count", 32'(bus.count), 32'd0);
    bus.spi_done = 1'b0;
    repeat (5) @(posedge clk); #1;
    send(8'h3C, 4, 0, 1);
    check("rearm_count", 32'(bus.count), 32'd1);
    drain();

    // Random stream with random back-pressure; waits keep the FIFO from overflowing.
    rand_en = 1;
    for (int n = 0; n < 48; n++) begin
      for (int w = 0; w < 500 && q.size() >= DEPTH; w++) begin
        @(posedge clk); #1;
      end
      if (q.size() >= DEPTH) check("rand_wait_timeout", q.size(), DEPTH - 1);
      send(8'($urandom), int'($urandom_range(3, 6)), 0, 0);
    end
    rand_en = 0;
    drain();
    check("final_ovf", 32'(bus.overflow), 32'd0);
    check("final_empty", 32'(bus.empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
